// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between N bus masters and rr_grant_arbiter.
// The masters drive r and rr_mode; the arbiter drives g, busy, owner and timeout.
interface rr_grant_arbiter_if #(
    parameter int unsigned N = 4
);
    localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   r;
    logic           rr_mode;
    logic [N-1:0]   g;
    logic           busy;
    logic [IDW-1:0] owner;
    logic           timeout;

    // Requester side
    modport master (
        output r,
        output rr_mode,
        input  g,
        input  busy,
        input  owner,
        input  timeout
    );

    // Arbiter side
    modport slave (
        input  r,
        input  rr_mode,
        output g,
        output busy,
        output owner,
        output timeout
    );
endinterface

// File: rtl/rr_grant_arbiter.sv
// N-requester grant arbiter with fixed-priority or round-robin selection.
// A grant is held while its owner keeps requesting. On release it passes
// straight to the next requester without an idle cycle. Under contention the
// owner is preempted after MAX_HOLD cycles.
// Optional feature macro ARB_LOCK_EN: adds a lock input that suppresses
// preemption while high during a grant.
module rr_grant_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic clk,
    input  logic resetn,
`ifdef ARB_LOCK_EN
    input  logic lock,
`endif
    rr_grant_arbiter_if.slave bus
);
    localparam int unsigned IDW      = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned HCW      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);
    localparam logic [N-1:0]   ONE_HOT0 = N'(1);
    localparam logic [IDW-1:0] PTR_RST  = IDW'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   g_q, g_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [HCW-1:0] hold_q, hold_d;
    logic           timeout_q, timeout_d;

    logic           lock_act;
    logic [N-1:0]   others;
    logic           owner_req;
    logic           preempt;
    logic [N-1:0]   elig;
    logic           win_found;
    logic [IDW-1:0] win_idx;
    logic [IDW-1:0] cand;
    int unsigned    start;

`ifdef ARB_LOCK_EN
    assign lock_act = lock;
`else
    assign lock_act = 1'b0;
`endif

    // Request view relative to the current owner
    always_comb begin
        others    = bus.r & ~g_q;
        owner_req = |(bus.r & g_q);
        elig      = (state_q == IDLE) ? bus.r : others;
    end

    // Winner search: lowest index in fixed mode, rotating from last owner + 1 in RR mode
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        start     = bus.rr_mode ? ((32'(ptr_q) + 32'd1) % N) : 32'd0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IDW'((start + k) % N);
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Preempt a saturated owner when someone else is waiting and lock is not held
    assign preempt = (MAX_HOLD > 0) && (hold_q == HOLD_MAX) && owner_req
                     && win_found && !lock_act;

    // State and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            g_q       <= '0;
            owner_q   <= '0;
            ptr_q     <= PTR_RST;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state decision: new grant, hold, release or preempt
    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = GRANT;
                    g_d     = ONE_HOT0 << win_idx;
                    owner_d = win_idx;
                    ptr_d   = win_idx;
                    hold_d  = HCW'(1);
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    if (win_found) begin
                        g_d     = ONE_HOT0 << win_idx;
                        owner_d = win_idx;
                        ptr_d   = win_idx;
                        hold_d  = HCW'(1);
                    end else begin
                        state_d = IDLE;
                        g_d     = '0;
                        hold_d  = '0;
                    end
                end else if (preempt) begin
                    g_d       = ONE_HOT0 << win_idx;
                    owner_d   = win_idx;
                    ptr_d     = win_idx;
                    hold_d    = HCW'(1);
                    timeout_d = 1'b1;
                end else if ((MAX_HOLD > 0) && (hold_q != HOLD_MAX)) begin
                    hold_d = hold_q + HCW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                g_d     = '0;
                hold_d  = '0;
            end
        endcase
    end

    // Drive the bus from registered state
    always_comb begin
        bus.g       = g_q;
        bus.busy    = |g_q;
        bus.owner   = owner_q;
        bus.timeout = timeout_q;
    end

    // Grant vector is never more than one-hot, and only nonzero in GRANT
    a_onehot: assert property (@(posedge clk) disable iff (!resetn)
        $onehot0(g_q) && ((g_q != '0) == (state_q == GRANT)));

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter (N=4, MAX_HOLD=8).
// Expectations are queued when stimulus is driven and compared after the edge.
module tb_rr_grant_arbiter;
    localparam int unsigned N        = 4;
    localparam int unsigned MAX_HOLD = 8;
    localparam int unsigned IDW      = $clog2(N);

    logic clk;
    logic resetn;
    logic lock;

    rr_grant_arbiter_if #(.N(N)) bus();

    rr_grant_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk    (clk),
        .resetn (resetn),
`ifdef ARB_LOCK_EN
        .lock   (lock),
`endif
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   g;
        logic           busy;
        logic [IDW-1:0] owner;
        logic           timeout;
    } exp_t;

    exp_t sbq[$];
    int   errors;
    int   checks;

    // Reference model state
    logic m_busy;
    int   m_owner;
    int   m_hold;
    int   m_ptr;
    logic m_to;

    function automatic exp_t mk(input logic [N-1:0] gv, input int ov, input logic tv);
        exp_t e;
        e.g       = gv;
        e.busy    = |gv;
        e.owner   = IDW'(ov);
        e.timeout = tv;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_hold  = 0;
        m_ptr   = N - 1;
        m_to    = 1'b0;
    endtask

    function automatic int pick(input logic [N-1:0] el, input logic rr);
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = rr ? ((m_ptr + 1 + k) % N) : k;
            if (el[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [N-1:0] rv, input logic rr, input logic lk);
        logic [N-1:0] oth;
        int w;
        m_to = 1'b0;
        if (!m_busy) begin
            w = pick(rv, rr);
            if (w >= 0) begin
                m_busy = 1'b1; m_owner = w; m_ptr = w; m_hold = 1;
            end
        end else begin
            oth = rv;
            oth[m_owner] = 1'b0;
            w = pick(oth, rr);
            if (!rv[m_owner]) begin
                if (w >= 0) begin
                    m_owner = w; m_ptr = w; m_hold = 1;
                end else begin
                    m_busy = 1'b0; m_hold = 0;
                end
            end else if (MAX_HOLD > 0 && m_hold >= MAX_HOLD && w >= 0 && !lk) begin
                m_owner = w; m_ptr = w; m_hold = 1; m_to = 1'b1;
            end else if (m_hold < MAX_HOLD) begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    function automatic exp_t model_exp();
        logic [N-1:0] gv;
        gv = '0;
        if (m_busy) gv[m_owner] = 1'b1;
        return mk(gv, m_owner, m_to);
    endfunction

    task automatic do_reset();
        resetn      = 1'b0;
        bus.r       = '0;
        bus.rr_mode = 1'b0;
        lock        = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_reset();
        exp_t e;
        resetn      = 1'b0;
        bus.r       = '0;
        bus.rr_mode = 1'b0;
        lock        = 1'b0;
        #3;
        sbq.push_back(mk('0, 0, 1'b0));
        e = sbq.pop_front();
        checks++;
        if ({bus.g, bus.busy, bus.owner, bus.timeout} !== {e.g, e.busy, e.owner, e.timeout}) begin
            errors++;
            $display("FAIL reset got g=%b busy=%b owner=%0d timeout=%b want g=%b busy=%b owner=%0d timeout=%b",
                     bus.g, bus.busy, bus.owner, bus.timeout, e.g, e.busy, e.owner, e.timeout);
        end
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_async_reset();
        exp_t e;
        logic [N-1:0] rs [3];
        logic [N-1:0] eg [3];
        int           eo [3];
        do_reset();
        rs = '{4'b0001, 4'b0100, 4'b0100};
        eg = '{4'b0001, 4'b0100, 4'b0100};
        eo = '{0, 2, 2};
        for (int i = 0; i < 3; i++) begin
            bus.r = rs[i];
            sbq.push_back(mk(eg[i], eo[i], 1'b0));
            tick();
            e = sbq.pop_front();
            checks++;
            if ({bus.g, bus.busy, bus.owner, bus.timeout} !== {e.g, e.busy, e.owner, e.timeout}) begin
                errors++;
                $display("FAIL async_reset_setup step=%0d got g=%b busy=%b owner=%0d timeout=%b want g=%b busy=%b owner=%0d timeout=%b",
                         i, bus.g, bus.busy, bus.owner, bus.timeout, e.g, e.busy, e.owner, e.timeout);
            end
        end
        // Mid-cycle reset, no clock edge before the check
        #2;
        resetn = 1'b0;
        sbq.push_back(mk('0, 0, 1'b0));
        #1;
        e = sbq.pop_front();
        checks++;
        if ({bus.g, bus.busy, bus.owner, bus.timeout} !== {e.g, e.busy, e.owner, e.timeout}) begin
            errors++;
            $display("FAIL async_reset got g=%b busy=%b owner=%0d timeout=%b want g=%b busy=%b owner=%0d timeout=%b",
                     bus.g, bus.busy, bus.owner, bus.timeout, e.g, e.busy, e.owner, e.timeout);
        end
        bus.r = '0;
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_fixed_priority();
        exp_t e;
        logic [N-1:0] rs [8];
        logic [N-1:0] eg [8];
        int           eo [8];
        do_reset();
        bus.rr_mode = 1'b0;
        rs = '{4'b0110, 4'b0100, 4'b0000, 4'b1100, 4'b1101, 4'b1001, 4'b1000, 4'b0000};
        eg = '{4'b0010, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0001, 4'b1000, 4'b0000};
        eo = '{1, 2, 2, 2, 2, 0, 3, 3};
        for (int i = 0; i < 8; i++) begin
            bus.r = rs[i];
            sbq.push_back(mk(eg[i], eo[i], 1'b0));
            tick();
            e = sbq.pop_front();
            checks++;
            if ({bus.g, bus.busy, bus.owner, bus.timeout} !== {e.g, e.busy, e.owner, e.timeout}) begin
                errors++;
                $display("FAIL fixed_priority step=%0d got g=%b busy=%b owner=%0d timeout=%b want g=%b busy=%b owner=%0d timeout=%b",
                         i, bus.g, bus.busy, bus.owner, bus.timeout, e.g, e.busy, e.owner, e.timeout);
            end
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   slot;
        do_reset();
        bus.rr_mode = 1'b1;
        bus.r       = 4'b1111;
        for (int c = 1; c <= 40; c++) begin
            slot = ((c - 1) / MAX_HOLD) % N;
            sbq.push_back(mk(N'(1) << slot, slot, (c > 1) && (((c - 1) % MAX_HOLD) == 0)));
            tick();
            e = sbq.pop_front();
            checks++;
            if ({bus.g, bus.busy, bus.owner, bus.timeout} !== {e.g, e.busy, e.owner, e.timeout}) begin
                errors++;
                $display("FAIL round_robin cyc=%0d got g=%b busy=%b owner=%0d timeout=%b want g=%b busy=%b owner=%0d timeout=%b",
                         c, bus.g, bus.busy, bus.owner, bus.timeout, e.g, e.busy, e.owner, e.timeout);
            end
        end
        bus.r = '0;
        tick();
    endtask

    task automatic test_uncontended();
        exp_t e;
        do_reset();
        bus.rr_mode = 1'b0;
        for (int c = 0; c < 23; c++) begin
            if (c < 20) begin
                bus.r = 4'b0001;
                sbq.push_back(mk(4'b0001, 0, 1'b0));
            end else if (c == 20) begin
                bus.r = 4'b0011;
                sbq.push_back(mk(4'b0010, 1, 1'b1));
            end else if (c == 21) begin
                bus.r = 4'b0011;
                sbq.push_back(mk(4'b0010, 1, 1'b0));
            end else begin
                bus.r = 4'b0000;
                sbq.push_back(mk(4'b0000, 1, 1'b0));
            end
            tick();
            e = sbq.pop_front();
            checks++;
            if ({bus.g, bus.busy, bus.owner, bus.timeout} !== {e.g, e.busy, e.owner, e.timeout}) begin
                errors++;
                $display("FAIL uncontended cyc=%0d got g=%b busy=%b owner=%0d timeout=%b want g=%b busy=%b owner=%0d timeout=%b",
                         c, bus.g, bus.busy, bus.owner, bus.timeout, e.g, e.busy, e.owner, e.timeout);
            end
        end
    endtask

    task automatic test_release_idle();
        exp_t e;
        logic [N-1:0] rs [6];
        logic [N-1:0] eg [6];
        int           eo [6];
        do_reset();
        bus.rr_mode = 1'b1;
        rs = '{4'b0100, 4'b0000, 4'b0101, 4'b0101, 4'b0100, 4'b0000};
        eg = '{4'b0100, 4'b0000, 4'b0001, 4'b0001, 4'b0100, 4'b0000};
        eo = '{2, 2, 0, 0, 2, 2};
        for (int i = 0; i < 6; i++) begin
            bus.r = rs[i];
            sbq.push_back(mk(eg[i], eo[i], 1'b0));
            tick();
            e = sbq.pop_front();
            checks++;
            if ({bus.g, bus.busy, bus.owner, bus.timeout} !== {e.g, e.busy, e.owner, e.timeout}) begin
                errors++;
                $display("FAIL release_idle step=%0d got g=%b busy=%b owner=%0d timeout=%b want g=%b busy=%b owner=%0d timeout=%b",
                         i, bus.g, bus.busy, bus.owner, bus.timeout, e.g, e.busy, e.owner, e.timeout);
            end
        end
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        exp_t e;
        do_reset();
        bus.rr_mode = 1'b0;
        bus.r       = 4'b0011;
        for (int c = 0; c < 22; c++) begin
            lock = (c < 21);
            if (c < 21) sbq.push_back(mk(4'b0001, 0, 1'b0));
            else        sbq.push_back(mk(4'b0010, 1, 1'b1));
            tick();
            e = sbq.pop_front();
            checks++;
            if ({bus.g, bus.busy, bus.owner, bus.timeout} !== {e.g, e.busy, e.owner, e.timeout}) begin
                errors++;
                $display("FAIL lock cyc=%0d got g=%b busy=%b owner=%0d timeout=%b want g=%b busy=%b owner=%0d timeout=%b",
                         c, bus.g, bus.busy, bus.owner, bus.timeout, e.g, e.busy, e.owner, e.timeout);
            end
        end
        lock  = 1'b0;
        bus.r = '0;
        tick();
    endtask
`endif

    task automatic test_random();
        exp_t e;
        logic lk;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) bus.r = N'($urandom_range(0, (1 << N) - 1));
            if ($urandom_range(0, 15) == 0) bus.rr_mode = ~bus.rr_mode;
`ifdef ARB_LOCK_EN
            if ($urandom_range(0, 7) == 0) lock = ~lock;
            lk = lock;
`else
            lk = 1'b0;
`endif
            model_step(bus.r, bus.rr_mode, lk);
            sbq.push_back(model_exp());
            tick();
            e = sbq.pop_front();
            checks++;
            if ({bus.g, bus.busy, bus.owner, bus.timeout} !== {e.g, e.busy, e.owner, e.timeout}) begin
                errors++;
                $display("FAIL random cyc=%0d r=%b rr=%b got g=%b busy=%b owner=%0d timeout=%b want g=%b busy=%b owner=%0d timeout=%b",
                         c, bus.r, bus.rr_mode, bus.g, bus.busy, bus.owner, bus.timeout, e.g, e.busy, e.owner, e.timeout);
            end
        end
        bus.r = '0;
        lock  = 1'b0;
        tick();
    endtask

    initial begin
        clk         = 1'b0;
        resetn      = 1'b0;
        lock        = 1'b0;
        bus.r       = '0;
        bus.rr_mode = 1'b0;
        errors      = 0;
        checks      = 0;
        model_reset();
        test_reset();
        test_async_reset();
        test_fixed_priority();
        test_round_robin();
        test_uncontended();
        test_release_idle();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule
